mem_arbiter_latency_ctrl: RTL and testbench

- Shares one single-port synchronous memory between the instruction fetch unit (IFU) and the load/store unit (LSU), one transaction at a time.
- Round-robin arbitration.
- Inserts a fixed or LFSR-randomised wait before each memory access to emulate memory latency in simulation.
- Sits between the IFU/LSU request channels and the memory model in the NPC core.

---
 rtl/mem_arbiter_latency_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_arbiter_latency_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_latency_ctrl.sv
// Round-robin arbiter sharing one synchronous memory between IFU and LSU, with a
// programmable (fixed or LFSR-jittered) wait before each access to emulate latency.
module mem_arbiter_latency_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MIN_DELAY   = 2,
  parameter int unsigned RANDOM      = 1,
  parameter logic [7:0]  JITTER_MASK = 8'h0F,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_en,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MaskW   = DATA_W / 8;
  localparam logic [7:0]  SeedEff = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_next;
  logic                last_lsu_q;
  logic [31:0]         counter_q, target_q, target_next, jitter;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MaskW-1:0]    wmask_q;
  logic                owner_lsu_q;
  logic                first_q;
  logic [DATA_W-1:0]   rdata_q, resp_data;
  logic                in_idle, in_resp, grant_ifu, grant_lsu, accept, resp_hs;

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign jitter    = {24'd0, lfsr_q & JITTER_MASK};
  assign target_next = (RANDOM != 0) ? (32'(MIN_DELAY) + jitter) : 32'(MIN_DELAY);

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign in_idle   = rst & (state_q == StIdle);
  assign in_resp   = (state_q == StResp);
  assign grant_ifu = ifu_req_valid & (~lsu_req_valid | last_lsu_q);
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);

  assign ifu_req_ready = in_idle & grant_ifu;
  assign lsu_req_ready = in_idle & grant_lsu;
  assign accept        = ifu_req_ready | lsu_req_ready;
  assign resp_hs       = in_resp & (owner_lsu_q ? lsu_resp_ready : ifu_resp_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StWait;
      StWait:   if (counter_q == target_q) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (resp_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_en    = (state_q == StAccess);
  assign mem_wen   = mem_en & wen_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign mem_wmask = mem_en ? wmask_q : '0;

  // First RESP cycle forwards the memory output; later cycles replay the captured copy.
  assign resp_data      = wen_q ? '0 : (first_q ? mem_rdata : rdata_q);
  assign ifu_resp_valid = in_resp & ~owner_lsu_q;
  assign lsu_resp_valid = in_resp & owner_lsu_q;
  assign ifu_resp_rdata = ifu_resp_valid ? resp_data : '0;
  assign lsu_resp_rdata = lsu_resp_valid ? resp_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lfsr_q      <= SeedEff;
      last_lsu_q  <= 1'b1;
      counter_q   <= '0;
      target_q    <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      owner_lsu_q <= 1'b0;
      first_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next;
      first_q <= (state_q == StAccess);
      if (first_q) rdata_q <= mem_rdata;
      if (accept) begin
        owner_lsu_q <= lsu_req_ready;
        last_lsu_q  <= lsu_req_ready;
        addr_q      <= lsu_req_ready ? lsu_req_addr : ifu_req_addr;
        wen_q       <= lsu_req_ready & lsu_req_wen;
        wdata_q     <= lsu_req_ready ? lsu_req_wdata : '0;
        wmask_q     <= lsu_req_ready ? lsu_req_wmask : '1;
        counter_q   <= '0;
        target_q    <= target_next;
      end else if (state_q == StWait) begin
        counter_q <= counter_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_latency_ctrl.sv
// Scoreboard bench: a fixed-latency instance (dut0, with a writable memory) and a
// jittered instance (dut1) whose latency is predicted by a reference LFSR.
module tb_mem_arbiter_latency_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: RANDOM = 0, MIN_DELAY = 2
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr, ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [3:0]  lsu_req_wmask, mem_wmask;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter_latency_ctrl #(
    .ADDR_W(32), .DATA_W(32), .MIN_DELAY(2), .RANDOM(0), .JITTER_MASK(8'h0F), .LFSR_SEED(8'hA5)
  ) dut0 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // dut1: RANDOM = 1, IFU only
  logic        r_ifu_req_valid, r_ifu_req_ready, r_ifu_resp_valid, r_ifu_resp_ready;
  logic [31:0] r_ifu_req_addr, r_ifu_resp_rdata, r_lsu_resp_rdata;
  logic        r_lsu_req_ready, r_lsu_resp_valid;
  logic        r_mem_en, r_mem_wen;
  logic [31:0] r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic [3:0]  r_mem_wmask;

  mem_arbiter_latency_ctrl #(
    .ADDR_W(32), .DATA_W(32), .MIN_DELAY(2), .RANDOM(1), .JITTER_MASK(8'h0F), .LFSR_SEED(8'hA5)
  ) dut1 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(r_ifu_req_valid), .ifu_req_ready(r_ifu_req_ready),
    .ifu_req_addr(r_ifu_req_addr),
    .ifu_resp_valid(r_ifu_resp_valid), .ifu_resp_ready(r_ifu_resp_ready),
    .ifu_resp_rdata(r_ifu_resp_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(r_lsu_req_ready), .lsu_req_addr(32'd0),
    .lsu_req_wen(1'b0), .lsu_req_wdata(32'd0), .lsu_req_wmask(4'd0),
    .lsu_resp_valid(r_lsu_resp_valid), .lsu_resp_ready(1'b0),
    .lsu_resp_rdata(r_lsu_resp_rdata),
    .mem_en(r_mem_en), .mem_wen(r_mem_wen), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_wmask(r_mem_wmask), .mem_rdata(r_mem_rdata)
  );

  function automatic logic [31:0] pat(input logic [7:0] i);
    if (i == 8'd0) return 32'h1234_5678;
    return {16'hC0DE, i, ~i};
  endfunction

  // Memory models: dut0 writable, dut1 read-only pattern.
  logic [31:0] mem0 [256];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= pat(8'(i));
      mem_init <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem0[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem0[mem_addr[9:2]];
    end
  end
  always @(posedge clk) if (r_mem_en) r_mem_rdata <= pat(r_mem_addr[9:2]);

  // Reference LFSR, x^8+x^6+x^5+x^4+1, seeded 0xA5.
  logic [7:0] mlfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) mlfsr <= 8'hA5;
    else mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  // mem_en observer for dut0
  int          en_cnt = 0, en_cyc = 0, wen_bad = 0;
  logic        en_wen;
  logic [31:0] en_addr, en_wdata;
  logic [3:0]  en_mask;
  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt   <= en_cnt + 1;
      en_cyc   <= cyc;
      en_wen   <= mem_wen;
      en_addr  <= mem_addr;
      en_wdata <= mem_wdata;
      en_mask  <= mem_wmask;
    end
    if (mem_wen && !mem_en) wen_bad <= wen_bad + 1;
  end

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] sb1[$];
  logic [31:0] ref0 [256];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full dut0 transaction; entered and left at a negedge.
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] iaddr,
                         input logic [31:0] laddr, input bit lwen, input logic [31:0] lwdata,
                         input logic [3:0] lmask, input int stall,
                         output bit who, output int t_acc, output int lat);
    bit          got;
    exp_t        e;
    logic [31:0] held;
    ifu_req_valid = iv;  ifu_req_addr  = iaddr;
    lsu_req_valid = lv;  lsu_req_addr  = laddr;
    lsu_req_wen   = lwen; lsu_req_wdata = lwdata; lsu_req_wmask = lmask;
    got = 1'b0; who = 1'b0; t_acc = 0; lat = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        got   = 1'b1;
        who   = lsu_req_ready;
        t_acc = cyc;
        check("ready_onehot", 32'(ifu_req_ready & lsu_req_ready), 32'd0);
        e.lsu = who;
        if (!who) begin
          e.data = ref0[iaddr[9:2]];
        end else if (lwen) begin
          for (int b = 0; b < 4; b++)
            if (lmask[b]) ref0[laddr[9:2]][8*b +: 8] = lwdata[8*b +: 8];
          e.data = 32'd0;
        end else begin
          e.data = ref0[laddr[9:2]];
        end
        sb.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      check("req_timeout", 32'd0, 32'd1);
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = (stall > 0);
    check("ready_in_wait", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ifu_resp_valid || lsu_resp_valid) begin
        got = 1'b1;
        lat = cyc - t_acc;
        check("resp_owner", {30'd0, ifu_resp_valid, lsu_resp_valid}, who ? 32'd1 : 32'd2);
        held = who ? lsu_resp_rdata : ifu_resp_rdata;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("resp_rdata", held, e.data);
        end
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(who ? lsu_resp_valid : ifu_resp_valid), 32'd1);
          check("stall_rdata", who ? lsu_resp_rdata : ifu_resp_rdata, held);
          check("stall_gate", {30'd0, mem_en, lsu_req_ready}, 32'd0);
        end
        if (who) lsu_resp_ready = 1'b1;
        else ifu_resp_ready = 1'b1;
        @(posedge clk); #1;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic rnd_txn(input logic [31:0] addr, output int lat, output int exp_lat);
    bit got;
    int t;
    r_ifu_req_valid = 1'b1;
    r_ifu_req_addr  = addr;
    got = 1'b0; t = 0; lat = 0; exp_lat = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (r_ifu_req_ready) begin
        got     = 1'b1;
        t       = cyc;
        exp_lat = 5 + int'(mlfsr & 8'h0F);
        sb1.push_back(pat(addr[9:2]));
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    r_ifu_req_valid = 1'b0;
    if (!got) begin
      check("rnd_req_timeout", 32'd0, 32'd1);
      return;
    end
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (r_ifu_resp_valid) begin
        got = 1'b1;
        lat = cyc - t;
        check("rnd_rdata", r_ifu_resp_rdata, sb1.pop_front());
        r_ifu_resp_ready = 1'b1;
        @(posedge clk); #1;
        r_ifu_resp_ready = 1'b0;
      end
    end
    if (!got) check("rnd_resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  bit who;
  int t_acc, lat, e0, bad_cnt, rl, rexp, rmin, rmax;

  initial begin
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 1'b0;
    r_ifu_req_valid = 1'b0; r_ifu_req_addr = '0; r_ifu_resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref0[i] = pat(8'(i));

    // Reset: requests present but nothing may be accepted.
    repeat (3) @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    check("rst_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    check("rst_mem_ctl", {30'd0, mem_en, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fixed-latency IFU read.
    e0 = en_cnt;
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 4'h0, 0, who, t_acc, lat);
    check("t1_who", 32'(who), 32'd0);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_mem_en_cycle", 32'(en_cyc - t_acc), 32'd4);
    check("t1_mem_en_count", 32'(en_cnt - e0), 32'd1);
    check("t1_mem_addr", en_addr, 32'h8000_0000);
    check("t1_mem_wen_mask", {27'd0, en_wen, en_mask}, 32'h0000_000F);

    // Round-robin from a fresh reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, 1'b1, 32'h8000_0040 + 32'(8 * i), 32'h8000_0100 + 32'(4 * i),
              (i == 3), 32'hA5A5_0000 + 32'(i), 4'hF, 0, who, t_acc, lat);
      check("rr_order", 32'(who), 32'(i % 2));
    end

    // Masked LSU write then read-back.
    e0 = en_cnt;
    run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, who, t_acc, lat);
    check("wr_lat", 32'(lat), 32'd5);
    check("wr_mem_en_count", 32'(en_cnt - e0), 32'd1);
    check("wr_mem_addr", en_addr, 32'h8000_0010);
    check("wr_mem_wdata", en_wdata, 32'hDEAD_BEEF);
    check("wr_mem_wen_mask", {27'd0, en_wen, en_mask}, 32'h0000_0013);
    run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 0, who, t_acc, lat);

    // Response back-pressure for 10 cycles with a competing LSU request.
    run_txn(1'b1, 1'b0, 32'h8000_0010, 32'h8000_0020, 1'b0, 32'd0, 4'h0, 10, who, t_acc, lat);

    // Reset during WAIT drops the transaction.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0030;
    #1;
    check("drop_accept", 32'(ifu_req_ready), 32'd1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e0 = en_cnt;
    rst = 1'b0;
    #1;
    check("drop_rst_out", {28'd0, ifu_resp_valid, lsu_resp_valid, mem_en, mem_wen}, 32'd0);
    check("drop_rst_addr", mem_addr | ifu_resp_rdata | lsu_resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifu_resp_valid || lsu_resp_valid || mem_en) bad_cnt++;
    end
    check("drop_no_activity", 32'(bad_cnt), 32'd0);
    check("drop_mem_en_count", 32'(en_cnt - e0), 32'd0);
    run_txn(1'b1, 1'b0, 32'h8000_0030, 32'd0, 1'b0, 32'd0, 4'h0, 0, who, t_acc, lat);
    check("post_rst_lat", 32'(lat), 32'd5);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("wen_qualified", 32'(wen_bad), 32'd0);

    // Jittered latency on dut1.
    rmin = 1000; rmax = 0;
    for (int k = 0; k < 100; k++) begin
      rnd_txn(32'h8000_0000 + 32'(4 * (k % 64)), rl, rexp);
      check("rnd_lat", 32'(rl), 32'(rexp));
      if (rl < rmin) rmin = rl;
      if (rl > rmax) rmax = rl;
    end
    check("rnd_lat_min", 32'(rmin >= 5), 32'd1);
    check("rnd_lat_max", 32'(rmax <= 20), 32'd1);
    check("rnd_lat_varies", 32'(rmin != rmax), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
